idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It registers decoded operands and control from the decode stage. It resolves RAW hazards by forwarding from the MEM and WB stages, and drives the ALU operands `srca_e`/`srcb_e` and the 3-bit `alucontrol_e`. It also detects load-use hazards and requests a decode stall while inserting a bubble into EX.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd1_d  in  XLEN  decode rs1 read data
rd2_d  in  XLEN  decode rs2 read data
imm_d  in  XLEN  extended immediate
pc_d  in  XLEN  decode PC
rs1_d, rs2_d, rd_d  in  REGW each  decode register indices
alucontrol_d  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt)
alusrc_d  in  1  1 = srcb is immediate
regwrite_d, memwrite_d, branch_d, jump_d  in  1 each  decode control
resultsrc_d  in  2  00 alu, 01 load, 10 pc+4
stall_e  in  1  hold EX register (downstream stall)
flush_e  in  1  squash EX register (branch/jump taken)
aluresult_m  in  XLEN  MEM-stage ALU result
rd_m  in  REGW  MEM-stage destination
regwrite_m  in  1  MEM-stage write enable
result_w  in  XLEN  WB-stage result
rd_w  in  REGW  WB-stage destination
regwrite_w  in  1  WB-stage write enable
srca_e, srcb_e  out  XLEN each  ALU operands
writedata_e  out  XLEN  forwarded rs2 value for stores
alucontrol_e  out  3  registered ALU op
pc_e, imm_e  out  XLEN each  registered PC / immediate
rd_e  out  REGW  registered destination
regwrite_e, memwrite_e, branch_e, jump_e  out  1 each  registered control
resultsrc_e  out  2  registered result select
stall_d  out  1  load-use stall request to fetch/decode

Behaviour:
- Reset: async on `rst_n` low. All EX registers clear to 0, so EX holds a NOP with all control low and `rd_e`=0. `stall_d` = 0.
- Register update on the rising edge, priority order:
  - `flush_e`: load bubble.
  - `stall_e`: hold all registers.
  - `stall_d` (load-use): load bubble.
  - Otherwise: load all `*_d` inputs.
- Bubble: `regwrite`, `memwrite`, `branch`, `jump` = 0; `resultsrc` = 00; `alucontrol` = 000; `rd` = 0; data fields = 0.
- Latency: decode inputs appear on EX outputs 1 cycle after capture. Forwarding muxes are combinational on the registered values.
- Registered internal: `rs1_e`, `rs2_e`, `rd1_e`, `rd2_e`, `alusrc_e` (rs indices are zeroed by a bubble).
- Forward select A: 
  - MEM if `regwrite_m` and `rd_m`!=0 and `rd_m`==`rs1_e`.
  - Else WB if `regwrite_w` and `rd_w`!=0 and `rd_w`==`rs1_e`.
  - Else `rd1_e`.
  - MEM has priority over WB.
- Forward select B: same rule applied to `rs2_e`/`rd2_e`. The result drives `writedata_e`.
- `srca_e` = forwarded A. `srcb_e` = `alusrc_e` ? `imm_e` : forwarded B.
- x0 is never forwarded. A write to x0 in MEM/WB leaves the register-file value in place.
- `stall_d` (combinational) = `resultsrc_e`==01 and `rd_e`!=0 and (`rd_e`==`rs1_d` or `rd_e`==`rs2_d`). This is asserted regardless of `stall_e`/`flush_e`; the priority order above governs the register.
- After a load-use bubble, the load sits in MEM. The dependent instruction is captured next cycle and receives the load data by WB forwarding one cycle later.
- Forwarding from MEM is never required for a load in MEM: the load-use bubble guarantees this.
- Simultaneous `flush_e` and `stall_e`: the flush wins.
- Reset mid-stall: registers clear immediately and the hold is abandoned.

Test Plan:
- Reset then idle: `rst_n`=0, inputs random → all outputs 0 and `stall_d`=0; after release with no valid decode, `alucontrol_e`=000 and `regwrite_e`=0.
- MEM forward: EX add rs1=x5, `rd_m`=5, `regwrite_m`=1, `aluresult_m`=0x0000_1234, `rd1_e`=0x7 → `srca_e`=0x0000_1234; same with `rd_m`=0 → `srca_e`=0x7.
- MEM over WB priority: `rd_m`=`rd_w`=3, `aluresult_m`=0xAAAA_0000, `result_w`=0x5555_0000, rs2=x3, `alusrc`=0 → `srcb_e`=`writedata_e`=0xAAAA_0000; with `alusrc`=1 and `imm`=0x10 → `srcb_e`=0x10 and `writedata_e`=0xAAAA_0000.
- Load-use: EX lw x7 (`resultsrc`=01), decode add rs1=x7 → `stall_d`=1, next edge EX bubble (`regwrite_e`=0); following cycle add captured, `result_w`=0xDEAD_BEEF with `rd_w`=7 → `srca_e`=0xDEAD_BEEF.
- Load to x0: lw rd=x0, decode rs1=x0 → `stall_d`=0.
- Flush vs stall: `stall_e`=1 and `flush_e`=1 in the same cycle with sub in decode → EX becomes a bubble; `stall_e`=1 alone → EX outputs unchanged across 3 edges.

Source files
------------

// File: rtl/idex_stage_if.sv
// ID/EX stage bus: decode-side operands and control, MEM/WB forwarding
// sources, and the execute-side operands/control driven by the stage.
interface idex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    // decode stage
    logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d;
    logic [REGW-1:0] rs1_d, rs2_d, rd_d;
    logic [2:0]      alucontrol_d;
    logic            alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
    logic [1:0]      resultsrc_d;

    // pipeline control
    logic            stall_e, flush_e;

    // forwarding sources
    logic [XLEN-1:0] aluresult_m;
    logic [REGW-1:0] rd_m;
    logic            regwrite_m;
    logic [XLEN-1:0] result_w;
    logic [REGW-1:0] rd_w;
    logic            regwrite_w;

    // execute stage
    logic [XLEN-1:0] srca_e, srcb_e, writedata_e, pc_e, imm_e;
    logic [2:0]      alucontrol_e;
    logic [REGW-1:0] rd_e;
    logic            regwrite_e, memwrite_e, branch_e, jump_e;
    logic [1:0]      resultsrc_e;
    logic            stall_d;

    // driver of decode/forwarding signals (decode stage or bench)
    modport master (
        output rd1_d, rd2_d, imm_d, pc_d, rs1_d, rs2_d, rd_d, alucontrol_d,
               alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
               stall_e, flush_e, aluresult_m, rd_m, regwrite_m,
               result_w, rd_w, regwrite_w,
        input  srca_e, srcb_e, writedata_e, pc_e, imm_e, alucontrol_e, rd_e,
               regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e, stall_d
    );

    // the ID/EX stage itself
    modport slave (
        input  rd1_d, rd2_d, imm_d, pc_d, rs1_d, rs2_d, rd_d, alucontrol_d,
               alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
               stall_e, flush_e, aluresult_m, rd_m, regwrite_m,
               result_w, rd_w, regwrite_w,
        output srca_e, srcb_e, writedata_e, pc_e, imm_e, alucontrol_e, rd_e,
               regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e, stall_d
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// hazard detection. A bubble is an all-zero EX register (NOP, rd=x0).
module idex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic         clk,
    input logic         rst_n,
    idex_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [2:0]      alucontrol;
        logic            alusrc;
        logic            regwrite;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic [1:0]      resultsrc;
    } ex_t;

    ex_t             d_in;
    ex_t             ex_q;
    logic            load_use;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // Pack decode-stage fields into one record for the EX register.
    always_comb begin
        d_in            = '0;
        d_in.rd1        = bus.rd1_d;
        d_in.rd2        = bus.rd2_d;
        d_in.imm        = bus.imm_d;
        d_in.pc         = bus.pc_d;
        d_in.rs1        = bus.rs1_d;
        d_in.rs2        = bus.rs2_d;
        d_in.rd         = bus.rd_d;
        d_in.alucontrol = bus.alucontrol_d;
        d_in.alusrc     = bus.alusrc_d;
        d_in.regwrite   = bus.regwrite_d;
        d_in.memwrite   = bus.memwrite_d;
        d_in.branch     = bus.branch_d;
        d_in.jump       = bus.jump_d;
        d_in.resultsrc  = bus.resultsrc_d;
    end

    // Load in EX whose destination is read by the instruction in decode.
    assign load_use = (ex_q.resultsrc == 2'b01) && (ex_q.rd != '0) &&
                      ((ex_q.rd == bus.rs1_d) || (ex_q.rd == bus.rs2_d));

    // EX register: flush beats hold, hold beats load-use bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every EX field is reset so the stage comes up holding a NOP;
        // state is updated with non-blocking assignments so all fields move
        // together on the edge.
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush_e) begin
            ex_q <= '0;
        end else if (!bus.stall_e) begin
            ex_q <= load_use ? '0 : d_in;
        end
    end

    // Operand forwarding: MEM beats WB, x0 is never forwarded.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        fwd_a = ex_q.rd1;
        fwd_b = ex_q.rd2;
        if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == ex_q.rs1) begin
            fwd_a = bus.aluresult_m;
        end else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == ex_q.rs1) begin
            fwd_a = bus.result_w;
        end
        if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == ex_q.rs2) begin
            fwd_b = bus.aluresult_m;
        end else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == ex_q.rs2) begin
            fwd_b = bus.result_w;
        end
    end

    assign bus.srca_e       = fwd_a;
    assign bus.srcb_e       = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign bus.writedata_e  = fwd_b;
    assign bus.alucontrol_e = ex_q.alucontrol;
    assign bus.pc_e         = ex_q.pc;
    assign bus.imm_e        = ex_q.imm;
    assign bus.rd_e         = ex_q.rd;
    assign bus.regwrite_e   = ex_q.regwrite;
    assign bus.memwrite_e   = ex_q.memwrite;
    assign bus.branch_e     = ex_q.branch;
    assign bus.jump_e       = ex_q.jump;
    assign bus.resultsrc_e  = ex_q.resultsrc;
    assign bus.stall_d      = load_use;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed hazard scenarios plus a
// randomized run, all compared against an instruction-level reference model.
module tb_idex_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    idex_stage_if #(.XLEN(32), .REGW(5)) bus ();

    idex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently occupying EX.
    typedef struct packed {
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [2:0]  op;
        logic        use_imm;
        logic        wr_reg;
        logic        wr_mem;
        logic        is_br;
        logic        is_jmp;
        logic [1:0]  res_sel;
    } instr_t;

    instr_t m_ex;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] regfile_val);
        if (bus.regwrite_m && bus.rd_m != 0 && bus.rd_m == src) return bus.aluresult_m;
        if (bus.regwrite_w && bus.rd_w != 0 && bus.rd_w == src) return bus.result_w;
        return regfile_val;
    endfunction

    function automatic logic exp_stall();
        return m_ex.res_sel == 2'b01 && m_ex.dst != 0 &&
               (m_ex.dst == bus.rs1_d || m_ex.dst == bus.rs2_d);
    endfunction

    function automatic instr_t decoded();
        instr_t t;
        t.a_val   = bus.rd1_d;       t.b_val  = bus.rd2_d;
        t.imm     = bus.imm_d;       t.pc     = bus.pc_d;
        t.src1    = bus.rs1_d;       t.src2   = bus.rs2_d;
        t.dst     = bus.rd_d;        t.op     = bus.alucontrol_d;
        t.use_imm = bus.alusrc_d;    t.wr_reg = bus.regwrite_d;
        t.wr_mem  = bus.memwrite_d;  t.is_br  = bus.branch_d;
        t.is_jmp  = bus.jump_d;      t.res_sel = bus.resultsrc_d;
        return t;
    endfunction

    task automatic check_all();
        logic [31:0] b_fwd;
        b_fwd = operand(m_ex.src2, m_ex.b_val);
        check("srca",    bus.srca_e,      operand(m_ex.src1, m_ex.a_val));
        check("srcb",    bus.srcb_e,      m_ex.use_imm ? m_ex.imm : b_fwd);
        check("wdata",   bus.writedata_e, b_fwd);
        check("aluc",    32'(bus.alucontrol_e), 32'(m_ex.op));
        check("pc",      bus.pc_e,        m_ex.pc);
        check("imm",     bus.imm_e,       m_ex.imm);
        check("rd",      32'(bus.rd_e),   32'(m_ex.dst));
        check("regw",    32'(bus.regwrite_e), 32'(m_ex.wr_reg));
        check("memw",    32'(bus.memwrite_e), 32'(m_ex.wr_mem));
        check("branch",  32'(bus.branch_e),   32'(m_ex.is_br));
        check("jump",    32'(bus.jump_e),     32'(m_ex.is_jmp));
        check("rsrc",    32'(bus.resultsrc_e), 32'(m_ex.res_sel));
        check("stall_d", 32'(bus.stall_d), 32'(exp_stall()));
    endtask

    // Called at a negedge with inputs already applied: check, clock, advance model.
    task automatic tick();
        logic st;
        #1;
        check_all();
        st = exp_stall();
        @(posedge clk);
        if (!rst_n)            m_ex = '0;
        else if (bus.flush_e)  m_ex = '0;
        else if (bus.stall_e)  m_ex = m_ex;
        else if (st)           m_ex = '0;
        else                   m_ex = decoded();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd1_d = '0; bus.rd2_d = '0; bus.imm_d = '0; bus.pc_d = '0;
        bus.rs1_d = '0; bus.rs2_d = '0; bus.rd_d = '0; bus.alucontrol_d = '0;
        bus.alusrc_d = 0; bus.regwrite_d = 0; bus.memwrite_d = 0;
        bus.branch_d = 0; bus.jump_d = 0; bus.resultsrc_d = '0;
        bus.stall_e = 0; bus.flush_e = 0;
        bus.aluresult_m = '0; bus.rd_m = '0; bus.regwrite_m = 0;
        bus.result_w = '0; bus.rd_w = '0; bus.regwrite_w = 0;
    endtask

    task automatic random_inputs(input bit with_ctrl);
        bus.rd1_d = $urandom; bus.rd2_d = $urandom; bus.imm_d = $urandom; bus.pc_d = $urandom;
        bus.rs1_d = 5'($urandom_range(0, 7)); bus.rs2_d = 5'($urandom_range(0, 7));
        bus.rd_d  = 5'($urandom_range(0, 7));
        bus.alucontrol_d = 3'($urandom_range(0, 5));
        bus.alusrc_d = 1'($urandom); bus.regwrite_d = 1'($urandom);
        bus.memwrite_d = 1'($urandom); bus.branch_d = 1'($urandom); bus.jump_d = 1'($urandom);
        bus.resultsrc_d = 2'($urandom_range(0, 2));
        bus.aluresult_m = $urandom; bus.rd_m = 5'($urandom_range(0, 7)); bus.regwrite_m = 1'($urandom);
        bus.result_w = $urandom; bus.rd_w = 5'($urandom_range(0, 7)); bus.regwrite_w = 1'($urandom);
        bus.stall_e = with_ctrl && ($urandom_range(0, 5) == 0);
        bus.flush_e = with_ctrl && ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ex  = '0;
        rst_n = 1'b0;

        // Reset with random inputs: EX is a NOP, no stall request.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            random_inputs(1'b1);
            tick();
        end
        check("rst_pc", bus.pc_e, 32'h0);
        check("rst_srca", bus.srca_e, 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        check("idle_aluc", 32'(bus.alucontrol_e), 32'h0);
        check("idle_regw", 32'(bus.regwrite_e), 32'h0);

        // MEM forward: add rs1=x5 with rd1=7.
        bus.rs1_d = 5'd5; bus.rd1_d = 32'h7; bus.rd_d = 5'd9; bus.regwrite_d = 1;
        tick();
        idle_inputs();
        bus.rd_m = 5'd5; bus.regwrite_m = 1; bus.aluresult_m = 32'h0000_1234;
        #1 check("memfwd", bus.srca_e, 32'h0000_1234);
        bus.rd_m = 5'd0;
        #1 check("memfwd_x0", bus.srca_e, 32'h7);
        tick();

        // MEM over WB on rs2, with and without immediate.
        bus.rs2_d = 5'd3; bus.rd2_d = 32'h1; bus.rd_d = 5'd4; bus.regwrite_d = 1;
        tick();
        idle_inputs();
        bus.rd_m = 5'd3; bus.regwrite_m = 1; bus.aluresult_m = 32'hAAAA_0000;
        bus.rd_w = 5'd3; bus.regwrite_w = 1; bus.result_w    = 32'h5555_0000;
        #1 check("prio_srcb", bus.srcb_e, 32'hAAAA_0000);
        check("prio_wdata", bus.writedata_e, 32'hAAAA_0000);
        tick();
        bus.rs2_d = 5'd3; bus.rd2_d = 32'h1; bus.alusrc_d = 1; bus.imm_d = 32'h10; bus.memwrite_d = 1;
        tick();
        idle_inputs();
        bus.rd_m = 5'd3; bus.regwrite_m = 1; bus.aluresult_m = 32'hAAAA_0000;
        bus.rd_w = 5'd3; bus.regwrite_w = 1; bus.result_w    = 32'h5555_0000;
        #1 check("imm_srcb", bus.srcb_e, 32'h10);
        check("imm_wdata", bus.writedata_e, 32'hAAAA_0000);
        tick();

        // Load-use: lw x7, then add rs1=x7.
        idle_inputs();
        bus.rd_d = 5'd7; bus.regwrite_d = 1; bus.resultsrc_d = 2'b01;
        tick();
        idle_inputs();
        bus.rs1_d = 5'd7; bus.rd1_d = 32'h11; bus.rd_d = 5'd8; bus.regwrite_d = 1;
        #1 check("lu_stall", 32'(bus.stall_d), 32'h1);
        tick();
        check("lu_bubble", 32'(bus.regwrite_e), 32'h0);
        tick();
        bus.rd_w = 5'd7; bus.regwrite_w = 1; bus.result_w = 32'hDEAD_BEEF;
        #1 check("lu_wbfwd", bus.srca_e, 32'hDEAD_BEEF);
        tick();

        // Load to x0 never stalls.
        idle_inputs();
        bus.rd_d = 5'd0; bus.regwrite_d = 1; bus.resultsrc_d = 2'b01;
        tick();
        idle_inputs();
        bus.rs1_d = 5'd0;
        #1 check("lu_x0", 32'(bus.stall_d), 32'h0);
        tick();

        // Flush beats stall with sub in decode.
        bus.rd_d = 5'd6; bus.pc_d = 32'h100; bus.regwrite_d = 1;
        tick();
        bus.alucontrol_d = 3'b001; bus.rd_d = 5'd2; bus.pc_d = 32'h104;
        bus.stall_e = 1; bus.flush_e = 1;
        tick();
        check("flush_regw", 32'(bus.regwrite_e), 32'h0);
        check("flush_rd", 32'(bus.rd_e), 32'h0);
        bus.stall_e = 0; bus.flush_e = 0;
        tick();
        bus.pc_d = 32'h200; bus.alucontrol_d = 3'b100; bus.stall_e = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pc", bus.pc_e, 32'h104);
            check("hold_aluc", 32'(bus.alucontrol_e), 32'h1);
        end

        // Reset mid-stall clears immediately.
        #1 rst_n = 1'b0;
        m_ex = '0;
        #1 check("rst_mid_pc", bus.pc_e, 32'h0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            random_inputs(1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
